// File: rtl/hbus_arb_pkg.sv
// Shared types and defaults for the hyperbus command arbiter.
// Latency: n/a (package). Backpressure: n/a.
package hbus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } arb_state_t;

    localparam int HB_ADDR_W         = 32;
    localparam int HB_DATA_W         = 16;
    localparam int HB_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/hbus_rr_pick.sv
// Combinational round-robin picker: first requester after i_last (mod NREQ) wins.
// Latency: 0 cycles. Backpressure: none, pure function of its inputs.
module hbus_rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IDX_W'((int'(i_last) + k) % NREQ);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/hbus_arbiter.sv
// Round-robin share of one hyperbus core between NREQ requesters; one transaction in flight.
// Latency: >= 5 cycles plus core busy time. Optional watchdog: HBUS_ARB_TIMEOUT_EN.
module hbus_arbiter
    import hbus_arb_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int ADDR_W         = HB_ADDR_W,
    parameter int DATA_W         = HB_DATA_W,
    parameter int TIMEOUT_CYCLES = HB_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [ADDR_W-1:0]        hb_addr,
    output logic [DATA_W-1:0]        hb_wdata,
    input  logic [DATA_W-1:0]        hb_rdata,
    output logic                     hb_wrq,
    output logic                     hb_rrq,
    input  logic                     hb_busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] r_gidx;
    logic             r_we;

    logic [NREQ-1:0]  w_grant;
    logic [IDX_W-1:0] w_gidx;
    logic             w_any;
    logic             w_grant_now;
    logic             w_done;
    logic             w_tmo;

    hbus_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    assign w_grant_now = (r_state == IDLE) && w_any;
    assign w_done      = (r_state == WAIT_DONE) && !hb_busy;

`ifdef HBUS_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo;

    // Counts every cycle spent waiting on the core; a normal completion wins a tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (r_state == WAIT_START || r_state == WAIT_DONE) begin
            r_tmo <= r_tmo + 1'b1;
        end else begin
            r_tmo <= '0;
        end
    end

    assign w_tmo = (r_state == WAIT_START || r_state == WAIT_DONE) && !w_done &&
                   (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:       if (w_any)   w_state_nxt = ISSUE;
            ISSUE:                   w_state_nxt = WAIT_START;
            WAIT_START: if (hb_busy) w_state_nxt = WAIT_DONE;
            WAIT_DONE:  if (w_done)  w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
        if (w_tmo) begin
            w_state_nxt = IDLE;
        end
    end

    // Strobes are registered from ISSUE, so they are visible in the first WAIT_START cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            hb_addr   <= '0;
            hb_wdata  <= '0;
            hb_wrq    <= 1'b0;
            hb_rrq    <= 1'b0;
            r_last    <= IDX_W'(NREQ - 1);
            r_gidx    <= '0;
            r_we      <= 1'b0;
`ifdef HBUS_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            hb_wrq    <= 1'b0;
            hb_rrq    <= 1'b0;
`ifdef HBUS_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            if (w_grant_now) begin
                req_ready <= w_grant;
                r_gidx    <= w_gidx;
                r_we      <= req_we[w_gidx];
                hb_addr   <= req_addr[w_gidx*ADDR_W +: ADDR_W];
                hb_wdata  <= req_wdata[w_gidx*DATA_W +: DATA_W];
            end
            if (r_state == ISSUE) begin
                hb_wrq <= r_we;
                hb_rrq <= !r_we;
            end
            if (w_done || w_tmo) begin
                rsp_valid <= ONE_HOT0 << r_gidx;
                r_last    <= r_gidx;
                if (w_tmo) begin
                    rsp_rdata <= '0;
                end else if (!r_we) begin
                    rsp_rdata <= hb_rdata;
                end
`ifdef HBUS_ARB_TIMEOUT_EN
                rsp_err <= w_tmo;
`endif
            end
        end
    end

endmodule

// File: tb/tb_hbus_arbiter.sv
// Directed plus randomized bench for hbus_arbiter with a behavioural core and reference model.
// Timeout steps are compiled in only with HBUS_ARB_TIMEOUT_EN.
module tb_hbus_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;
    logic [AW-1:0]        hb_addr;
    logic [DW-1:0]        hb_wdata;
    logic [DW-1:0]        hb_rdata;
    logic                 hb_wrq;
    logic                 hb_rrq;
    logic                 hb_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hbus_arbiter #(
        .NREQ           (NREQ),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .hb_addr   (hb_addr),
        .hb_wdata  (hb_wdata),
        .hb_rdata  (hb_rdata),
        .hb_wrq    (hb_wrq),
        .hb_rrq    (hb_rrq),
        .hb_busy   (hb_busy)
    );

    // Behavioural hyperbus core: busy for core_len cycles after a strobe; fast mode
    // raises busy combinationally in the strobe cycle itself.
    int          core_cnt;
    int          core_len;
    logic        core_fast;
    logic        core_stuck;
    logic [15:0] core_mem [256];
    logic        core_wr  [256];

    function automatic logic [7:0] cidx(input logic [31:0] a);
        return a[15:8] ^ a[7:0];
    endfunction

    assign hb_busy = (core_cnt > 0) || (core_fast && (hb_wrq || hb_rrq));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_cnt <= 0;
        end else if (hb_wrq || hb_rrq) begin
            core_cnt <= core_fast ? core_len - 1 : core_len;
            if (hb_wrq) begin
                core_mem[cidx(hb_addr)] <= hb_wdata;
                core_wr[cidx(hb_addr)]  <= 1'b1;
            end else if (core_wr[cidx(hb_addr)] === 1'b1) begin
                hb_rdata <= core_mem[cidx(hb_addr)];
            end else begin
                hb_rdata <= (cidx(hb_addr) == 8'h01) ? 16'hA55A : 16'hDEAD;
            end
        end else if (core_cnt > 0 && !core_stuck) begin
            core_cnt <= core_cnt - 1;
        end
    end

    // Reference model state
    int          model_last;
    logic [15:0] model_rd;
    logic [15:0] ref_mem [logic [31:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic we, input logic [31:0] a, input logic [15:0] d);
        req_valid[r]          = 1'b1;
        req_we[r]             = we;
        req_addr[r*AW +: AW]  = a;
        req_wdata[r*DW +: DW] = d;
    endtask

    task automatic serve(input bit drop, output int g, output logic [15:0] rd, output logic err,
                         output int nw, output int nr, output logic [31:0] sa, output logic [15:0] swd,
                         output logic stable, output int ncyc);
        bit got;
        int rg;
        g = -1; rd = '0; err = 1'b0; nw = 0; nr = 0; sa = '0; swd = '0; stable = 1'b1; ncyc = 0;
        got = 1'b0; rg = -1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1'b1;
        end
        chk("ready_seen", got, 1);
        g = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : -2;
        if (drop) req_valid = '0;
        got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (hb_wrq) nw++;
            if (hb_rrq) nr++;
            if (hb_wrq || hb_rrq) begin
                sa = hb_addr; swd = hb_wdata; ncyc = 0;
            end else begin
                ncyc++;
            end
            if ((nw + nr) > 0 && (hb_addr !== sa || hb_wdata !== swd)) stable = 1'b0;
            if (rsp_valid != '0) begin
                got = 1'b1;
                rg  = (rsp_valid == 2'b01) ? 0 : (rsp_valid == 2'b10) ? 1 : -2;
                rd  = rsp_rdata;
                err = rsp_err;
            end
        end
        chk("rsp_seen", got, 1);
        chk("rsp_idx", rg, g);
    endtask

    task automatic txn(input string tag, input bit drop, input bit exp_tmo, output int g);
        int          eg;
        int          c;
        logic        ewe;
        logic [31:0] ea;
        logic [15:0] ewd, erd;
        logic [15:0] rd;
        logic        err, stable;
        int          nw, nr, ncyc;
        logic [31:0] sa;
        logic [15:0] swd;
        eg = -1;
        for (int k = 1; k <= NREQ; k++) begin
            c = (model_last + k) % NREQ;
            if (eg < 0 && req_valid[c]) eg = c;
        end
        if (eg < 0) eg = 0;
        ewe = req_we[eg];
        ea  = req_addr[eg*AW +: AW];
        ewd = req_wdata[eg*DW +: DW];
        if (exp_tmo)                erd = 16'h0000;
        else if (ewe)               erd = model_rd;
        else if (ref_mem.exists(ea)) erd = ref_mem[ea];
        else                        erd = 16'hDEAD;
        serve(drop, g, rd, err, nw, nr, sa, swd, stable, ncyc);
        chk({tag, "_grant"}, g, eg);
        chk({tag, "_wrq"}, nw, ewe ? 1 : 0);
        chk({tag, "_rrq"}, nr, ewe ? 0 : 1);
        chk({tag, "_addr"}, sa, ea);
        if (ewe) chk({tag, "_wdata"}, swd, ewd);
        chk({tag, "_stable"}, stable, 1);
        chk({tag, "_rdata"}, rd, erd);
        chk({tag, "_err"}, err, exp_tmo);
        if (exp_tmo) chk({tag, "_tmo_window"}, (ncyc >= 16 && ncyc <= 17), 1);
        model_last = eg;
        model_rd   = erd;
        if (ewe && !exp_tmo) ref_mem[ea] = ewd;
    endtask

    initial begin
        int   g;
        bit   got;
        int   r;
        rst        = 1'b1;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        core_len   = 4;
        core_fast  = 1'b0;
        core_stuck = 1'b0;
        model_last = NREQ - 1;
        model_rd   = 16'h0000;
        ref_mem[32'h100] = 16'hA55A;

        #1;
        chk("rst_ctl",  {req_ready, rsp_valid, rsp_err, hb_wrq, hb_rrq}, 0);
        chk("rst_addr", hb_addr, 0);
        chk("rst_data", {rsp_rdata, hb_wdata}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single read from requester 0
        core_len = 10;
        set_req(0, 1'b0, 32'h0000_0100, 16'h0000);
        txn("rd0", 1'b1, 1'b0, g);

        // Write from requester 1; rsp_rdata must keep the previous read value
        set_req(1, 1'b1, 32'h0000_2000, 16'h1234);
        txn("wr1", 1'b1, 1'b0, g);

        // Both held continuously: strict alternation
        core_len = 3;
        set_req(0, 1'b0, 32'h0000_0100, 16'h0000);
        set_req(1, 1'b0, 32'h0000_2000, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            txn("rr", (i == 5), 1'b0, g);
            chk("rr_order", g, i % 2);
        end
        req_valid = '0;

        // Reset during WAIT_DONE
        set_req(0, 1'b0, 32'h0000_0304, 16'h0000);
        txn("pre_rst", 1'b1, 1'b0, g);
        core_len = 10;
        set_req(1, 1'b0, 32'h0000_0308, 16'h0000);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1'b1;
        end
        chk("rstt_ready", got, 1);
        req_valid = '0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_ctl",  {req_ready, rsp_valid, rsp_err, hb_wrq, hb_rrq}, 0);
        chk("async_rst_addr", hb_addr, 0);
        chk("async_rst_data", {rsp_rdata, hb_wdata}, 0);
        @(negedge clk);
        chk("rst_no_rsp", rsp_valid, 0);
        rst        = 1'b0;
        model_last = NREQ - 1;
        model_rd   = 16'h0000;
        @(negedge clk);
        core_len = 3;
        set_req(0, 1'b0, 32'h0000_0100, 16'h0000);
        set_req(1, 1'b0, 32'h0000_2000, 16'h0000);
        txn("post_rst", 1'b1, 1'b0, g);
        chk("post_rst_g0", g, 0);

        // Busy rising with the strobe and lasting one cycle
        core_fast = 1'b1;
        core_len  = 1;
        set_req(1, 1'b1, 32'h0000_030C, 16'hBEEF);
        txn("fast_wr", 1'b1, 1'b0, g);
        @(negedge clk);
        chk("fast_single_rsp", rsp_valid, 0);
        set_req(0, 1'b0, 32'h0000_030C, 16'h0000);
        txn("fast_rd", 1'b1, 1'b0, g);
        core_fast = 1'b0;

`ifdef HBUS_ARB_TIMEOUT_EN
        core_len   = 5;
        core_stuck = 1'b1;
        set_req(1, 1'b0, 32'h0000_0100, 16'h0000);
        txn("tmo", 1'b1, 1'b1, g);
        core_stuck = 1'b0;
        set_req(0, 1'b0, 32'h0000_0100, 16'h0000);
        txn("after_tmo", 1'b1, 1'b0, g);
`endif

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            core_len  = $urandom_range(1, 6);
            core_fast = $urandom_range(0, 1);
            req_valid = '0;
            r = $urandom_range(1, 3);
            for (int q = 0; q < NREQ; q++) begin
                if (r[q]) set_req(q, 1'($urandom_range(0, 1)),
                                  32'h0000_0300 + 32'($urandom_range(0, 7) * 4),
                                  16'($urandom));
            end
            txn("rand", 1'b1, 1'b0, g);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hbus_arbiter.md
Name: hbus_arbiter

Overview:
- Shares one hyperbus controller core between NREQ independent requesters, e.g. CPU data port, DMA engine and video fetch.
- Arbitrates round-robin and drives the core's addr/din/wrq/rrq command interface.
- Tracks each transaction through the core's busy signal and returns completion plus read data to the granted requester.
- Sits between the system-side masters and the hyperbus core in the top level.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ADDR_W, 32, address width to the core.
- DATA_W, 16, data word width to the core.
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with HBUS_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, same clock as the hyperbus core.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester transfer request; held until accepted.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_W  flattened addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  flattened write data.
- req_ready  out  NREQ  one-cycle accept pulse, one-hot.
- rsp_valid  out  NREQ  one-cycle completion pulse, one-hot.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid; shared by all requesters.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- hb_addr  out  ADDR_W  to core addr.
- hb_wdata  out  DATA_W  to core din.
- hb_rdata  in  DATA_W  from core dout.
- hb_wrq  out  1  write strobe to core.
- hb_rrq  out  1  read strobe to core.
- hb_busy  in  1  core busy.

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, hb_addr=0, hb_wdata=0, hb_wrq=0, hb_rrq=0, state=IDLE, last_grant=NREQ-1 (requester 0 wins first).
- IDLE: if any req_valid, select via round-robin starting at last_grant+1 (mod NREQ). Latch that requester's addr/wdata/we into hb_addr/hb_wdata and an internal we flag. Pulse req_ready[g] for exactly 1 cycle. Go to ISSUE.
- IDLE with no req_valid: stay; all strobes 0.
- ISSUE: assert hb_wrq (we=1) or hb_rrq (we=0) for exactly 1 cycle, never both. Go to WAIT_START.
- WAIT_START: stay until hb_busy=1, then go to WAIT_DONE.
- WAIT_DONE: stay until hb_busy=0. Then register hb_rdata into rsp_rdata (reads only; unchanged on writes), pulse rsp_valid[g] for 1 cycle, set last_grant=g, go to IDLE.
- Signal stability: hb_addr/hb_wdata stay stable from ISSUE until the state returns to IDLE.
- Minimum occupancy: 5 cycles plus core busy time. The next grant can occur in the cycle after rsp_valid.
- Request changes: req_valid deasserting before req_ready is permitted; that request is simply not served. Request inputs are sampled only in IDLE, so changes in other states are ignored.
- Fairness: a requester that keeps req_valid asserted waits at most NREQ-1 other transactions.
- hb_busy already 1 on entry to WAIT_START: advance on the next edge.
- rst asserted mid-transaction: immediate return to reset values. The in-flight transaction is dropped with no rsp_valid. The core is expected to share the same rst.

Optional Feature:
- Macro: HBUS_ARB_TIMEOUT_EN.
- Defined: a counter runs in WAIT_START and WAIT_DONE. When it reaches TIMEOUT_CYCLES, the FSM jumps to completion: rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, last_grant=g, state back to IDLE.
- Undefined: no counter; rsp_err is tied to 0; the FSM waits indefinitely.

Decomposition:
- Package hbus_arb_pkg: state enum (IDLE, ISSUE, WAIT_START, WAIT_DONE), default ADDR_W/DATA_W constants, TIMEOUT_CYCLES default.
- Sub-module hbus_rr_pick: combinational round-robin picker. Inputs: req vector and last_grant. Outputs: one-hot grant and its index. Reusable by other shared-resource arbiters.

Test Plan:
- Reset, then req_valid[0]=1, we=0, addr=0x00000100. Core model holds busy for 10 cycles and returns dout=0xA55A. Expect: hb_rrq single pulse, hb_addr=0x100, rsp_valid[0] pulse, rsp_rdata=0xA55A, rsp_err=0.
- Write from requester 1: addr=0x2000, wdata=0x1234. Expect: hb_wrq single pulse, hb_wdata=0x1234 stable until IDLE, rsp_valid[1] pulse, rsp_rdata unchanged.
- req_valid=2'b11 held continuously for 6 transactions. Expect grant order 0,1,0,1,0,1 and no back-to-back grant to the same requester.
- Assert rst during WAIT_DONE. Expect all outputs 0 asynchronously, no rsp_valid, and the next request granted to requester 0.
- Core busy rising in the same cycle as the strobe, and busy lasting 1 cycle. Expect correct WAIT_START/WAIT_DONE progression and exactly one rsp_valid.
- With HBUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, core never drops busy. Expect rsp_valid with rsp_err=1 after 16 cycles and the arbiter back in IDLE, serving the next request.
